gray_bank_ptr_ctrl: RTL and testbench

- Controls a 4-bank codeword buffer between the syndrome/load stage (writer) and the Chien-search/correction stage (reader).
- Holds a write-bank pointer and a read-bank pointer, each a 2-bit gray counter; tracks bank occupancy.
- Issues full, empty and one-hot bank-select signals, so banks switch with single-bit pointer transitions.

---
 rtl/gray_bank_ptr_ctrl_pkg.sv | 51 +++++
 rtl/gray_bank_ptr_ctrl_if.sv | 38 +++
 rtl/gray_bank_ptr_ctrl_gray_ptr_2bit.sv | 42 ++++
 rtl/gray_bank_ptr_ctrl.sv | 109 ++++++++++
 tb/tb_gray_bank_ptr_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/gray_bank_ptr_ctrl_pkg.sv
// ============================================================================
// Module  : gray_bank_ptr_ctrl_pkg
// Brief   : Bank gray constants, widths and decode helpers for the 4-bank
//           codeword buffer pointer controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_bank_ptr_ctrl_pkg;

  localparam int LENGTH   = 2;
  localparam int CNT_W    = 3;
  localparam int NUM_BANK = 4;

  localparam logic [LENGTH-1:0] GC_BANK0 = 2'b00;
  localparam logic [LENGTH-1:0] GC_BANK1 = 2'b01;
  localparam logic [LENGTH-1:0] GC_BANK2 = 2'b11;
  localparam logic [LENGTH-1:0] GC_BANK3 = 2'b10;

  localparam logic [CNT_W-1:0] CNT_EMPTY = '0;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_BANK);

  function automatic logic [LENGTH-1:0] gc_next(input logic [LENGTH-1:0] gc);
    logic [LENGTH-1:0] nxt;
    nxt = GC_BANK0;
    case (gc)
      GC_BANK0: nxt = GC_BANK1;
      GC_BANK1: nxt = GC_BANK2;
      GC_BANK2: nxt = GC_BANK3;
      GC_BANK3: nxt = GC_BANK0;
      default:  nxt = GC_BANK0;
    endcase
    return nxt;
  endfunction

  function automatic logic [NUM_BANK-1:0] gc_to_onehot(input logic [LENGTH-1:0] gc);
    logic [NUM_BANK-1:0] sel;
    sel = 4'b0001;
    case (gc)
      GC_BANK0: sel = 4'b0001;
      GC_BANK1: sel = 4'b0010;
      GC_BANK2: sel = 4'b0100;
      GC_BANK3: sel = 4'b1000;
      default:  sel = 4'b0001;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_bank_ptr_ctrl_if.sv
// ============================================================================
// Module  : gray_bank_ptr_ctrl_if
// Brief   : Enable/strobe inputs and pointer/status outputs of the bank
//           pointer controller; master drives strobes, slave is the controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_bank_ptr_ctrl_if;
  import gray_bank_ptr_ctrl_pkg::*;

  logic                in_ctr_en;
  logic                in_wr_done;
  logic                in_rd_done;
  logic [LENGTH-1:0]   out_wr_GC;
  logic [LENGTH-1:0]   out_rd_GC;
  logic [NUM_BANK-1:0] out_wr_sel;
  logic [NUM_BANK-1:0] out_rd_sel;
  logic [CNT_W-1:0]    out_cnt;
  logic                out_full;
  logic                out_empty;
  logic                out_err;

  modport master (
    output in_ctr_en, in_wr_done, in_rd_done,
    input  out_wr_GC, out_rd_GC, out_wr_sel, out_rd_sel,
    input  out_cnt, out_full, out_empty, out_err
  );

  modport slave (
    input  in_ctr_en, in_wr_done, in_rd_done,
    output out_wr_GC, out_rd_GC, out_wr_sel, out_rd_sel,
    output out_cnt, out_full, out_empty, out_err
  );

endinterface

`default_nettype wire

// File: rtl/gray_bank_ptr_ctrl_gray_ptr_2bit.sv
// ============================================================================
// Module  : gray_ptr_2bit
// Brief   : 2-bit gray bank pointer, steps 00->01->11->10->00 on step_i.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_ptr_2bit
  import gray_bank_ptr_ctrl_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              in_ctr_Arst_n,
  input  wire logic              in_ctr_Srst,
  input  wire logic              step_i,
  output logic [LENGTH-1:0]      gc_o
);

  logic [LENGTH-1:0] gc_q;
  logic [LENGTH-1:0] gc_d;

  always_comb begin
    gc_d = gc_q;
    if (in_ctr_Srst) begin
      gc_d = GC_BANK0;
    end else if (step_i) begin
      gc_d = gc_next(gc_q);
    end
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      gc_q <= GC_BANK0;
    end else begin
      gc_q <= gc_d;
    end
  end

  assign gc_o = gc_q;

endmodule

`default_nettype wire

// File: rtl/gray_bank_ptr_ctrl.sv
// ============================================================================
// Module  : gray_bank_ptr_ctrl
// Brief   : Write/read gray bank pointers and occupancy for a 4-bank buffer.
//           Optional sticky dropped-strobe error: define GRAY_BANK_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_bank_ptr_ctrl
  import gray_bank_ptr_ctrl_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           in_ctr_Arst_n,
  input  wire logic           in_ctr_Srst,
  gray_bank_ptr_ctrl_if.slave bus
);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [LENGTH-1:0] w_wr_gc;
  logic [LENGTH-1:0] w_rd_gc;

  assign w_full  = (cnt_q == CNT_FULL);
  assign w_empty = (cnt_q == CNT_EMPTY);

  // Acceptance looks at the pre-edge flags, so a full buffer still takes a read
  assign w_wr_acc = bus.in_ctr_en & bus.in_wr_done & ~w_full;
  assign w_rd_acc = bus.in_ctr_en & bus.in_rd_done & ~w_empty;

  gray_ptr_2bit u_wr_ptr (
    .clk           (clk),
    .in_ctr_Arst_n (in_ctr_Arst_n),
    .in_ctr_Srst   (in_ctr_Srst),
    .step_i        (w_wr_acc),
    .gc_o          (w_wr_gc)
  );

  gray_ptr_2bit u_rd_ptr (
    .clk           (clk),
    .in_ctr_Arst_n (in_ctr_Arst_n),
    .in_ctr_Srst   (in_ctr_Srst),
    .step_i        (w_rd_acc),
    .gc_o          (w_rd_gc)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (in_ctr_Srst) begin
      cnt_d = CNT_EMPTY;
    end else if (w_wr_acc && !w_rd_acc) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!w_wr_acc && w_rd_acc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      cnt_q <= CNT_EMPTY;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef GRAY_BANK_ERR_EN
  logic err_q;
  logic err_d;
  logic w_drop;

  assign w_drop = bus.in_ctr_en &
                  ((bus.in_wr_done & w_full) | (bus.in_rd_done & w_empty));

  always_comb begin
    err_d = err_q;
    if (in_ctr_Srst) begin
      err_d = 1'b0;
    end else if (w_drop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.out_wr_GC  = w_wr_gc;
  assign bus.out_rd_GC  = w_rd_gc;
  assign bus.out_wr_sel = gc_to_onehot(w_wr_gc);
  assign bus.out_rd_sel = gc_to_onehot(w_rd_gc);
  assign bus.out_cnt    = cnt_q;
  assign bus.out_full   = w_full;
  assign bus.out_empty  = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_gray_bank_ptr_ctrl.sv
// ============================================================================
// Module  : tb_gray_bank_ptr_ctrl
// Brief   : Self-checking bench: bank-index reference model plus directed and
//           randomized strobes. Honours GRAY_BANK_ERR_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_bank_ptr_ctrl;

  logic clk;
  logic rst_n;
  logic srst;
  int   n_cmp;
  int   n_fail;

  gray_bank_ptr_ctrl_if bus ();

  gray_bank_ptr_ctrl dut (
    .clk           (clk),
    .in_ctr_Arst_n (rst_n),
    .in_ctr_Srst   (srst),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bank indices 0..3 and a fill count; gray code comes from a table
  logic [1:0] gc_tab [4];
  int  m_wr, m_rd, m_cnt;
  bit  m_err, m_wr_step, m_rd_step;
  bit  err_en;

  initial begin
    gc_tab[0] = 2'b00; gc_tab[1] = 2'b01; gc_tab[2] = 2'b11; gc_tab[3] = 2'b10;
`ifdef GRAY_BANK_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    bit wa, ra, drop;
    if (!rst_n || srst) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_err = 0;
      m_wr_step = 0; m_rd_step = 0;
    end else begin
      wa   = bus.in_ctr_en && bus.in_wr_done && (m_cnt < 4);
      ra   = bus.in_ctr_en && bus.in_rd_done && (m_cnt > 0);
      drop = bus.in_ctr_en && ((bus.in_wr_done && m_cnt == 4) ||
                               (bus.in_rd_done && m_cnt == 0));
      m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
      m_wr  = wa ? (m_wr + 1) % 4 : m_wr;
      m_rd  = ra ? (m_rd + 1) % 4 : m_rd;
      if (drop && err_en) m_err = 1;
      m_wr_step = wa;
      m_rd_step = ra;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_gc"},  32'(bus.out_wr_GC),  32'h0);
    chk({tag, "_rd_gc"},  32'(bus.out_rd_GC),  32'h0);
    chk({tag, "_cnt"},    32'(bus.out_cnt),    32'h0);
    chk({tag, "_empty"},  32'(bus.out_empty),  32'h1);
    chk({tag, "_full"},   32'(bus.out_full),   32'h0);
    chk({tag, "_wr_sel"}, 32'(bus.out_wr_sel), 32'h1);
    chk({tag, "_rd_sel"}, 32'(bus.out_rd_sel), 32'h1);
    chk({tag, "_err"},    32'(bus.out_err),    32'h0);
  endtask

  // Every-cycle comparison against the model, plus single-bit-step check
  logic [1:0] prev_wr, prev_rd;
  always @(negedge clk) begin
    chk("m_wr_gc",  32'(bus.out_wr_GC),  32'(gc_tab[m_wr]));
    chk("m_rd_gc",  32'(bus.out_rd_GC),  32'(gc_tab[m_rd]));
    chk("m_wr_sel", 32'(bus.out_wr_sel), 32'(1 << m_wr));
    chk("m_rd_sel", 32'(bus.out_rd_sel), 32'(1 << m_rd));
    chk("m_cnt",    32'(bus.out_cnt),    32'(m_cnt));
    chk("m_full",   32'(bus.out_full),   32'(m_cnt == 4));
    chk("m_empty",  32'(bus.out_empty),  32'(m_cnt == 0));
    chk("m_err",    32'(bus.out_err),    32'(m_err));
    if (m_wr_step) chk("wr_hamming", 32'($countones(bus.out_wr_GC ^ prev_wr)), 32'd1);
    if (m_rd_step) chk("rd_hamming", 32'($countones(bus.out_rd_GC ^ prev_rd)), 32'd1);
    prev_wr = bus.out_wr_GC;
    prev_rd = bus.out_rd_GC;
  end

  task automatic tick(input bit en, input bit wr, input bit rd);
    bus.in_ctr_en  = en;
    bus.in_wr_done = wr;
    bus.in_rd_done = rd;
    @(posedge clk);
    #1;
    bus.in_wr_done = 1'b0;
    bus.in_rd_done = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_gc [4];
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; srst = 1'b0;
    bus.in_ctr_en = 1'b0; bus.in_wr_done = 1'b0; bus.in_rd_done = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst");

    exp_gc[0] = 2'b01; exp_gc[1] = 2'b11; exp_gc[2] = 2'b10; exp_gc[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0);
      chk("fill_wr_gc", 32'(bus.out_wr_GC), 32'(exp_gc[i]));
      chk("fill_cnt",   32'(bus.out_cnt),   32'(i + 1));
      tick(1, 0, 0);
    end
    chk("fill_full",   32'(bus.out_full),   32'h1);
    chk("fill_wr_sel", 32'(bus.out_wr_sel), 32'h1);

    tick(1, 1, 0);
    chk("drop_cnt",   32'(bus.out_cnt),   32'd4);
    chk("drop_wr_gc", 32'(bus.out_wr_GC), 32'h0);
    chk("drop_err",   32'(bus.out_err),   32'(err_en));
    tick(1, 0, 0);
    chk("drop_err_sticky", 32'(bus.out_err), 32'(err_en));

    tick(1, 0, 1);
    tick(1, 0, 1);
    chk("drain_cnt",   32'(bus.out_cnt),   32'd2);
    chk("drain_rd_gc", 32'(bus.out_rd_GC), 32'b11);
    tick(1, 1, 1);
    chk("both_cnt",   32'(bus.out_cnt),   32'd2);
    chk("both_wr_gc", 32'(bus.out_wr_GC), 32'b01);
    chk("both_rd_gc", 32'(bus.out_rd_GC), 32'b10);
    chk("both_flags", 32'({bus.out_full, bus.out_empty}), 32'h0);

    srst = 1'b1;
    tick(1, 1, 1);
    srst = 1'b0;
    chk_reset_vals("srst");

    tick(1, 1, 1);
    chk("emp_cnt",   32'(bus.out_cnt),   32'd1);
    chk("emp_rd_gc", 32'(bus.out_rd_GC), 32'b00);
    chk("emp_wr_gc", 32'(bus.out_wr_GC), 32'b01);
    chk("emp_err",   32'(bus.out_err),   32'(err_en));

    for (int i = 0; i < 8; i++) tick(1, 1, 1);
    chk("wrap_wr_gc", 32'(bus.out_wr_GC), 32'b01);
    chk("wrap_rd_gc", 32'(bus.out_rd_GC), 32'b00);
    chk("wrap_cnt",   32'(bus.out_cnt),   32'd1);

    for (int i = 0; i < 3; i++) tick(0, 1, 1);
    chk("hold_cnt",   32'(bus.out_cnt),   32'd1);
    chk("hold_wr_gc", 32'(bus.out_wr_GC), 32'b01);

    tick(1, 1, 0);
    tick(1, 1, 0);
    chk("pre_arst_cnt", 32'(bus.out_cnt), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(posedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      srst = ($urandom_range(0, 63) == 0);
      tick(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end
    srst = 1'b0;
    tick(0, 0, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
